// File: rtl/codificador_op.sv
// Opcode encoder/sequencer: edge-detects one-hot request lines, queues them and
// issues their indices as ALU opcodes over valid/ready. CODIFICADOR_RR_EN selects round-robin arbitration.
module codificador_op #(
  parameter int OP_W  = 3,
  parameter int N_SEL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SEL-1:0] sel_in,
  output logic [OP_W-1:0]  Op,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [N_SEL-1:0] pending,
  output logic             overflow
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  if (N_SEL != 2**OP_W) begin : g_bad_params
    $error("codificador_op: N_SEL must equal 2**OP_W");
  end

  logic [0:0]       state;
  logic [N_SEL-1:0] sel_q;
  logic [N_SEL-1:0] rise;
  logic [N_SEL-1:0] clr;
  logic [OP_W-1:0]  grant_idx;
  logic             grant_any;
  logic             grant_en;

  assign rise = sel_in & ~sel_q;

`ifdef CODIFICADOR_RR_EN
  logic [OP_W-1:0] ptr;
  logic [OP_W-1:0] cand;

  // First pending bit at or after ptr, wrapping through the top index.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 0; i < N_SEL; i++) begin
      cand = ptr + OP_W'(i);
      if (!grant_any && pending[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_en) begin
      ptr <= grant_idx + OP_W'(1);
    end
  end
`else
  // Fixed priority: scanning downward lets the lowest set index win.
  always_comb begin
    grant_idx = '0;
    for (int i = N_SEL - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_idx = OP_W'(i);
      end
    end
    grant_any = |pending;
  end
`endif

  // Only registered pending feeds the grant; same-cycle rises wait an edge.
  assign grant_en = grant_any && ((state == IDLE) || op_ready);
  assign clr      = grant_en ? (N_SEL'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= sel_in;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      sel_q    <= sel_in;
      pending  <= (pending & ~clr) | rise;
      overflow <= |(rise & pending & ~clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      Op       <= '0;
      op_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            Op       <= grant_idx;
            op_valid <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (grant_en) begin
            Op <= grant_idx;
          end else if (op_ready) begin
            op_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          op_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_codificador_op.sv
// Self-checking bench for codificador_op: directed test-plan scenarios plus
// randomized traffic compared against a cycle-level behavioural queue model.
module tb_codificador_op;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sel_in;
  logic [2:0] Op;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] m_selq;
  logic [7:0] m_pend;
  int         m_op;
  logic       m_valid;
  logic       m_ovf;
  int         m_ptr;

  always #5 clk = ~clk;

  codificador_op #(.OP_W(3), .N_SEL(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel_in   (sel_in),
    .Op       (Op),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .pending  (pending),
    .overflow (overflow)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // First requested operation found when scanning from 'start' upward, wrapping at 8.
  function automatic int pickRequest(input logic [7:0] m, input int start);
    for (int k = 0; k < 8; k++) begin
      if (m[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic modelEdge();
    int         g;
    logic [7:0] rs;
    logic [7:0] cl;
    if (rst) begin
      m_selq = sel_in; m_pend = 8'h00; m_op = 0; m_valid = 1'b0; m_ovf = 1'b0; m_ptr = 0;
      return;
    end
    rs = sel_in & ~m_selq;
    g  = -1;
    if ((!m_valid || op_ready) && m_pend != 8'h00) begin
`ifdef CODIFICADOR_RR_EN
      g = pickRequest(m_pend, m_ptr);
`else
      g = pickRequest(m_pend, 0);
`endif
    end
    cl     = (g >= 0) ? (8'h01 << g) : 8'h00;
    m_ovf  = |(rs & m_pend & ~cl);
    m_pend = (m_pend & ~cl) | rs;
    if (g >= 0) begin
      m_op = g; m_valid = 1'b1; m_ptr = (g + 1) % 8;
    end else if (m_valid && op_ready) begin
      m_valid = 1'b0;
    end
    m_selq = sel_in;
  endtask

  // Drive inputs on the falling edge, advance the model at the rising edge, compare 1 ns later.
  task automatic applyStimulus(input logic r, input logic [7:0] s, input logic rdy);
    @(negedge clk);
    rst = r; sel_in = s; op_ready = rdy;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("Op",       {5'b0, Op},       8'(m_op));
    checkOutput("op_valid", {7'b0, op_valid}, {7'b0, m_valid});
    checkOutput("pending",  pending,          m_pend);
    checkOutput("overflow", {7'b0, overflow}, {7'b0, m_ovf});
  endtask

  initial begin
    logic [2:0] order [3];
`ifdef CODIFICADOR_RR_EN
    order[0] = 3'd7; order[1] = 3'd0; order[2] = 3'd2;
`else
    order[0] = 3'd0; order[1] = 3'd2; order[2] = 3'd7;
`endif
    rst = 1'b1; sel_in = 8'h01; op_ready = 1'b1;
    m_selq = 8'h00; m_pend = 8'h00; m_op = 0; m_valid = 1'b0; m_ovf = 1'b0; m_ptr = 0;

    // Line already high through reset release must not request.
    applyStimulus(1'b1, 8'h01, 1'b1);
    applyStimulus(1'b1, 8'h01, 1'b1);
    checkOutput("reset_op", {5'b0, Op}, 8'h00);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h01, 1'b1);
      checkOutput("held_pending", pending, 8'h00);
      checkOutput("held_valid", {7'b0, op_valid}, 8'h00);
    end

    // Single pulse on line 5: pending after edge k, issued after k+1 for one cycle.
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h20, 1'b1);
    checkOutput("pulse_pending", pending, 8'h20);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pulse_op", {5'b0, Op}, 8'h05);
    checkOutput("pulse_valid", {7'b0, op_valid}, 8'h01);
    checkOutput("pulse_cleared", pending, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pulse_idle", {7'b0, op_valid}, 8'h00);

    // Stall: Op 3 must hold while op_ready is low, then accept in one cycle.
    applyStimulus(1'b0, 8'h08, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h08, 1'b0);
      checkOutput("stall_op", {5'b0, Op}, 8'h03);
      checkOutput("stall_valid", {7'b0, op_valid}, 8'h01);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("stall_accept", {7'b0, op_valid}, 8'h00);

    // Simultaneous rises on 7, 2, 0 issue back-to-back in arbitration order.
    applyStimulus(1'b0, 8'h85, 1'b1);
    checkOutput("multi_pending", pending, 8'h85);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("multi_order", {5'b0, Op}, {5'b0, order[i]});
      checkOutput("multi_valid", {7'b0, op_valid}, 8'h01);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("multi_idle", {7'b0, op_valid}, 8'h00);

    // Duplicate request on line 4 while it waits behind a stalled opcode.
    applyStimulus(1'b0, 8'h02, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h10, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h10, 1'b0);
    checkOutput("ovf_pulse", {7'b0, overflow}, 8'h01);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovf_clear", {7'b0, overflow}, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovf_issue", {5'b0, Op}, 8'h04);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ovf_once", {7'b0, op_valid}, 8'h00);

    // Reset while issuing with C0 queued discards everything.
    applyStimulus(1'b0, 8'h01, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'hC0, 1'b0);
    checkOutput("pre_rst_pending", pending, 8'hC0);
    applyStimulus(1'b1, 8'hC0, 1'b0);
    checkOutput("rst_valid", {7'b0, op_valid}, 8'h00);
    checkOutput("rst_pending", pending, 8'h00);
    checkOutput("rst_op", {5'b0, Op}, 8'h00);

    // Random traffic: sparse line toggles, random ready, rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] s;
      s = sel_in ^ ((($urandom % 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      applyStimulus(($urandom % 200) == 0, s, ($urandom % 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
